// File: rtl/btn_pkg.sv
// Shared constants and FSM state encoding for the button conditioning block.
package btn_pkg;

  localparam int NUM_BTN          = 5;
  localparam int DEBOUNCE_CYC_DEF = 4;

  localparam int BTN_U = 4;
  localparam int BTN_D = 3;
  localparam int BTN_R = 2;
  localparam int BTN_L = 1;
  localparam int BTN_C = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_DOWN = 2'd2,
    ST_REL  = 2'd3
  } btn_state_e;

endpackage

// File: rtl/button_event_unit_if.sv
// Button bundle: raw levels in, press events and debounced levels out.
interface button_event_unit_if #(
  parameter int N_BTN = 5
);
  logic [N_BTN-1:0] btn_in;
  logic [N_BTN-1:0] press;
  logic [N_BTN-1:0] held;
  logic             any_held;

  modport master (output btn_in, input press, held, any_held);
  modport slave  (input btn_in, output press, held, any_held);
endinterface

// File: rtl/btn_debounce_fsm.sv
// One button: 2-flop synchronizer, debounce FSM, and optional auto-repeat
// counter (present only when BTN_AUTOREPEAT_EN is defined).
module btn_debounce_fsm
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
`ifdef BTN_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY  = 100,
  parameter int REPEAT_PERIOD = 20,
  parameter bit AUTOREPEAT    = 1'b0
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic req,
  output logic held
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [1:0]       sync_q;
  logic             level;
  btn_state_e       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             deb_req;

  // NOTE: non-blocking so sync_q[1] takes the previous sync_q[0]; blocking would collapse the chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[0], raw};
  end

  assign level = sync_q[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // NOTE: every output gets a default first, so no path leaves one unassigned (no latch).
  // cnt_next defaults to zero: the counter clears on every state entry.
  always_comb begin
    state_next = state;
    cnt_next   = '0;
    deb_req    = 1'b0;
    unique case (state)
      ST_IDLE: if (level) state_next = ST_ARM;
      ST_ARM: begin
        if (!level) begin
          state_next = ST_IDLE;
        end else if (cnt == CNT_LAST) begin
          state_next = ST_DOWN;
          deb_req    = 1'b1;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      ST_DOWN: if (!level) state_next = ST_REL;
      ST_REL: begin
        if (level) begin
          state_next = ST_DOWN;
        end else if (cnt == CNT_LAST) begin
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign held = (state == ST_DOWN) || (state == ST_REL);

`ifdef BTN_AUTOREPEAT_EN
  logic rep_req;

  if (AUTOREPEAT) begin : g_repeat
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] rep_cnt;
    logic             repeating;

    // First repeat after REPEAT_DELAY cycles in DOWN, then one every REPEAT_PERIOD.
    assign rep_req = (state == ST_DOWN) &&
                     (rep_cnt == (repeating ? REP_W'(REPEAT_PERIOD - 1)
                                            : REP_W'(REPEAT_DELAY - 1)));

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rep_cnt   <= '0;
        repeating <= 1'b0;
      end else if (state != ST_DOWN) begin
        rep_cnt   <= '0;
        repeating <= 1'b0;
      end else if (rep_req) begin
        rep_cnt   <= '0;
        repeating <= 1'b1;
      end else if (rep_cnt != '1) begin
        rep_cnt <= rep_cnt + REP_W'(1);
      end
    end
  end else begin : g_no_repeat
    assign rep_req = 1'b0;
  end

  assign req = deb_req | rep_req;
`else
  assign req = deb_req;
`endif

endmodule

// File: rtl/button_event_unit.sv
// Five debounced buttons feeding a fixed-priority (U>D>R>L>C) single-event arbiter.
// Define BTN_AUTOREPEAT_EN to add auto-repeat on U and D.
module button_event_unit
  import btn_pkg::*;
#(
  parameter int N_BTN        = NUM_BTN,
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
`ifdef BTN_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY  = 100,
  parameter int REPEAT_PERIOD = 20
`endif
) (
  input logic                clk,
  input logic                rst,
  button_event_unit_if.slave bus
);

  logic [N_BTN-1:0] req;
  logic [N_BTN-1:0] held;
  logic [N_BTN-1:0] press_next;
  logic [N_BTN-1:0] press_q;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_debounce_fsm #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
`ifdef BTN_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD),
      .AUTOREPEAT   ((i == BTN_U) || (i == BTN_D))
`endif
    ) u_fsm (
      .clk (clk),
      .rst (rst),
      .raw (bus.btn_in[i]),
      .req (req[i]),
      .held(held[i])
    );
  end

  // Highest index wins; losing requests are simply dropped.
  always_comb begin
    press_next = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (req[i]) press_next = N_BTN'(1) << i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) press_q <= '0;
    else      press_q <= press_next;
  end

  assign bus.press    = press_q;
  assign bus.held     = held;
  assign bus.any_held = |held;

endmodule

// File: tb/tb_button_event_unit.sv
// Scoreboard bench: stimulus queues expected press/held events by cycle; a monitor pops and compares.
module tb_button_event_unit;

  typedef struct {
    int         cyc;
    logic [4:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t press_q[$];
  exp_t held_q[$];

  button_event_unit_if #(.N_BTN(5)) bus ();

  button_event_unit dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_press(input int c, input logic [4:0] v);
    press_q.push_back('{cyc: c, val: v});
  endtask

  task automatic push_held(input int c, input logic [4:0] v);
    held_q.push_back('{cyc: c, val: v});
  endtask

  // Monitor: at each falling edge, cyc is the number of the last rising edge.
  always @(negedge clk) begin
    exp_t e;
    while (press_q.size() > 0 && press_q[0].cyc < cyc) begin
      e = press_q.pop_front();
      check("press_missed_cycle", 32'(cyc), 32'(e.cyc));
    end
    if (bus.press !== 5'b0) begin
      if (press_q.size() == 0) begin
        check("press_unexpected", 32'(bus.press), 32'(0));
      end else begin
        e = press_q.pop_front();
        check("press_value", 32'(bus.press), 32'(e.val));
        check("press_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    while (held_q.size() > 0 && held_q[0].cyc <= cyc) begin
      e = held_q.pop_front();
      check("held", 32'(bus.held), 32'(e.val));
      check("any_held", 32'(bus.any_held), 32'(|e.val));
    end
  end

  task automatic hold_btn(input logic [4:0] v, input int n);
    bus.btn_in = v;
    repeat (n) @(negedge clk);
    bus.btn_in = 5'b0;
  endtask

  initial begin
    int t0;
    int t1;
    bus.btn_in = 5'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("reset_press", 32'(bus.press), 32'(0));
    check("reset_held", 32'(bus.held), 32'(0));
    check("reset_any_held", 32'(bus.any_held), 32'(0));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Clean press of C for 10 cycles.
    t0 = cyc + 1;
    push_press(t0 + 6, 5'b00001);
    push_held(t0 + 5, 5'b00000);
    push_held(t0 + 6, 5'b00001);
    push_held(t0 + 15, 5'b00001);
    push_held(t0 + 16, 5'b00000);
    hold_btn(5'b00001, 10);
    repeat (12) @(negedge clk);

    // 3-cycle glitch on R: nothing changes.
    t0 = cyc + 1;
    push_held(t0 + 3, 5'b00000);
    push_held(t0 + 5, 5'b00000);
    push_held(t0 + 8, 5'b00000);
    hold_btn(5'b00100, 3);
    repeat (8) @(negedge clk);

    // U and C together: only U is emitted.
    t0 = cyc + 1;
    push_press(t0 + 6, 5'b10000);
    push_held(t0 + 6, 5'b10001);
    push_held(t0 + 15, 5'b10001);
    push_held(t0 + 16, 5'b00000);
    hold_btn(5'b10001, 10);
    repeat (12) @(negedge clk);

    // All five together: still only U.
    t0 = cyc + 1;
    push_press(t0 + 6, 5'b10000);
    push_held(t0 + 6, 5'b11111);
    push_held(t0 + 16, 5'b00000);
    hold_btn(5'b11111, 10);
    repeat (12) @(negedge clk);

    // Reset while D is down and still pressed.
    t0 = cyc + 1;
    push_press(t0 + 6, 5'b01000);
    push_held(t0 + 6, 5'b01000);
    bus.btn_in = 5'b01000;
    repeat (8) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("async_reset_held", 32'(bus.held), 32'(0));
    check("async_reset_any_held", 32'(bus.any_held), 32'(0));
    check("async_reset_press", 32'(bus.press), 32'(0));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    t1 = cyc + 1;
    push_press(t1 + 6, 5'b01000);
    push_held(t1 + 5, 5'b00000);
    push_held(t1 + 6, 5'b01000);
    repeat (10) @(negedge clk);
    t1 = cyc + 1;
    push_held(t1 + 5, 5'b01000);
    push_held(t1 + 6, 5'b00000);
    bus.btn_in = 5'b0;
    repeat (10) @(negedge clk);

    // L with release bounce: low 2, high 1, low 8.
    t0 = cyc + 1;
    push_press(t0 + 6, 5'b00010);
    push_held(t0 + 6, 5'b00010);
    push_held(t0 + 12, 5'b00010);
    push_held(t0 + 14, 5'b00010);
    push_held(t0 + 16, 5'b00010);
    push_held(t0 + 18, 5'b00010);
    push_held(t0 + 19, 5'b00000);
    hold_btn(5'b00010, 10);
    repeat (2) @(negedge clk);
    hold_btn(5'b00010, 1);
    repeat (8) @(negedge clk);
    repeat (5) @(negedge clk);

    // U held 150 cycles: one press, or repeats when auto-repeat is built in.
    t0 = cyc + 1;
    push_press(t0 + 6, 5'b10000);
`ifdef BTN_AUTOREPEAT_EN
    push_press(t0 + 106, 5'b10000);
    push_press(t0 + 126, 5'b10000);
    push_press(t0 + 146, 5'b10000);
`endif
    push_held(t0 + 149, 5'b10000);
    push_held(t0 + 156, 5'b00000);
    hold_btn(5'b10000, 150);
    repeat (25) @(negedge clk);

    check("press_queue_drained", 32'(press_q.size()), 32'(0));
    check("held_queue_drained", 32'(held_q.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
